// File: rtl/rd3_cg_pkg.sv
// Purpose : shared types and constants for the DDR read channel 3 coordinate generator.
// Latency : n/a (package only).
// Backpress: n/a.
package rd3_cg_pkg;

    // Scan state: IDLE after reset, RUN while bursts are being issued, DONE after the last burst.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit offsets of the coordinate fields inside image_addr.
    localparam int W_LSB = 16;
    localparam int H_LSB = 0;

    // err_flags bit indices (only used when RD3_CG_ERR_EN is defined).
    localparam int ERR_CREDIT_OVF = 0;
    localparam int ERR_FRAME_OVR  = 1;

endpackage

// File: rtl/rd3_credit_ctr.sv
// Purpose : saturating credit counter bounding outstanding read bursts.
// Latency : count updates on the edge after dec/inc; avail/ovf are combinational from the count.
// Backpress: avail low blocks the issuer; inc at full is dropped and flagged on ovf.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (count resets to CREDITS)
//   dec       - one credit consumed this cycle (only asserted while avail)
//   inc       - one credit returned this cycle
//   avail     - at least one credit held
//   ovf       - return arrived while already full (and not offset by a dec)
module rd3_credit_ctr #(
    parameter int CREDITS  = 8,
    parameter int CREDIT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dec,
    input  logic inc,
    output logic avail,
    output logic ovf
);

    logic [CREDIT_W-1:0] r_cnt;
    logic                w_full;

    assign w_full = (r_cnt == CREDIT_W'(CREDITS));
    assign avail  = (r_cnt != '0);
    assign ovf    = inc & ~dec & w_full;

    // dec and inc together cancel; a lone inc at full saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= CREDIT_W'(CREDITS);
        end else if (dec && !inc) begin
            r_cnt <= r_cnt - CREDIT_W'(1);
        end else if (inc && !dec && !w_full) begin
            r_cnt <= r_cnt + CREDIT_W'(1);
        end
    end

endmodule

// File: rtl/rd3_coord_gen.sv
// Purpose : raster-scans one frame in burst steps, emitting one {w,h} coordinate per DDR read burst.
// Latency : rd_vs seen high at edge N -> RUN after N+1 -> first image_addr_valid after N+2.
// Backpress: credit counter; with no credit the scan stalls, a returned credit at edge K re-issues after K+1.
//
// Optional build macro: RD3_CG_ERR_EN adds err_flags[1:0] (sticky credit overflow / frame overrun).
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   rd_vs             - read-side frame sync; rising edge starts (or restarts) a frame
//   credit_ret        - one-cycle pulse, one burst drained by the read-data path
//   image_addr_valid  - one-cycle pulse, image_addr carries a new coordinate
//   image_addr        - [16 +: IMAGE_SIZE] = w, [0 +: IMAGE_SIZE] = h, other bits 0; held while valid low
//   frame_busy        - high while in RUN
//   err_flags         - (RD3_CG_ERR_EN only) bit0 credit overflow, bit1 frame overrun
module rd3_coord_gen
    import rd3_cg_pkg::*;
#(
    parameter int IMAGE_W    = 1280,
    parameter int IMAGE_H    = 720,
    parameter int IMAGE_SIZE = 12,
    parameter int BURST_PIX  = 128,
    parameter int CREDITS    = 8,
    parameter int CREDIT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_vs,
    input  logic        credit_ret,
    output logic        image_addr_valid,
    output logic [31:0] image_addr,
    output logic        frame_busy
`ifdef RD3_CG_ERR_EN
    ,
    output logic [1:0]  err_flags
`endif
);

    // One extra bit so w + BURST_PIX cannot wrap before the end-of-line compare.
    localparam int CW = IMAGE_SIZE + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_vs_q;
    logic                  r_vs_d;
    logic                  w_rise;
    logic                  w_issue;
    logic                  w_line_end;
    logic                  w_last;
    logic                  w_avail;
    logic                  w_ovf;
    logic [IMAGE_SIZE-1:0] r_w_cnt;
    logic [IMAGE_SIZE-1:0] r_h_cnt;
    logic                  r_addr_vld;
    logic [31:0]           r_addr;
    logic [31:0]           w_addr_nxt;

    // rd_vs is registered before edge detection, which puts RUN one edge after
    // the first high sample and the first request one edge after that.
    assign w_rise = r_vs_q & ~r_vs_d;

    assign w_line_end = (({1'b0, r_w_cnt} + CW'(BURST_PIX)) == CW'(IMAGE_W));
    assign w_last     = w_line_end && (r_h_cnt == IMAGE_SIZE'(IMAGE_H - 1));

    always_comb begin
        w_addr_nxt                        = '0;
        w_addr_nxt[W_LSB +: IMAGE_SIZE]   = r_w_cnt;
        w_addr_nxt[H_LSB +: IMAGE_SIZE]   = r_h_cnt;
    end

    // A rise always wins over issuing: the restart cycle carries no request.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_rise) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!w_rise && w_avail) begin
                    w_issue = 1'b1;
                    if (w_last) w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_vs_q     <= 1'b0;
            r_vs_d     <= 1'b0;
            r_w_cnt    <= '0;
            r_h_cnt    <= '0;
            r_addr_vld <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_vs_q     <= rd_vs;
            r_vs_d     <= r_vs_q;
            r_addr_vld <= w_issue;
            if (w_rise) begin
                r_w_cnt <= '0;
                r_h_cnt <= '0;
            end else if (w_issue) begin
                r_addr <= w_addr_nxt;
                if (w_line_end) begin
                    r_w_cnt <= '0;
                    r_h_cnt <= r_h_cnt + IMAGE_SIZE'(1);
                end else begin
                    r_w_cnt <= r_w_cnt + IMAGE_SIZE'(BURST_PIX);
                end
            end
        end
    end

    // Returns are accepted in every state; in-flight data keeps returning across a restart.
    rd3_credit_ctr #(
        .CREDITS  (CREDITS),
        .CREDIT_W (CREDIT_W)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .dec   (w_issue),
        .inc   (credit_ret),
        .avail (w_avail),
        .ovf   (w_ovf)
    );

    assign image_addr_valid = r_addr_vld;
    assign image_addr       = r_addr;
    assign frame_busy       = (r_state == ST_RUN);

`ifdef RD3_CG_ERR_EN
    logic [1:0] r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            if (w_ovf)                       r_err[ERR_CREDIT_OVF] <= 1'b1;
            if (w_rise && r_state == ST_RUN) r_err[ERR_FRAME_OVR]  <= 1'b1;
        end
    end

    assign err_flags = r_err;
`else
    // Overflow is silently absorbed by the saturating counter in this build.
    logic w_ovf_unused;
    assign w_ovf_unused = w_ovf;
`endif

endmodule

// File: tb/tb_rd3_coord_gen.sv
// Purpose : scoreboard bench for rd3_coord_gen at default parameters.
// Latency : n/a.
// Backpress: bench drives credit_ret directly.
module tb_rd3_coord_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_vs = 1'b0;
    logic        credit_ret = 1'b0;
    logic        image_addr_valid;
    logic [31:0] image_addr;
    logic        frame_busy;
`ifdef RD3_CG_ERR_EN
    logic [1:0]  err_flags;
`endif

    always #5 clk = ~clk;

    rd3_coord_gen dut (
        .clk              (clk),
        .rst              (rst),
        .rd_vs            (rd_vs),
        .credit_ret       (credit_ret),
        .image_addr_valid (image_addr_valid),
        .image_addr       (image_addr),
        .frame_busy       (frame_busy)
`ifdef RD3_CG_ERR_EN
        ,
        .err_flags        (err_flags)
`endif
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    logic [31:0] last_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] coord(input int w, input int h);
        return (32'(w) << 16) | 32'(h);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse is matched against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && image_addr_valid) begin
            if (pulse_cnt == 0) first_cyc = cyc;
            pulse_cnt++;
            last_cyc  = cyc;
            last_addr = image_addr;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=%h required=no_pulse", image_addr);
            end else begin
                chk("sb_addr", image_addr, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rd_vs = 1'b0;
        credit_ret = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
    endtask

    push_frame_dummy u_unused_guard ();

    // rd_vs rise with no returns except optionally one at edge N+ret_edge; checks per-edge valid timing.
    task automatic frame_pattern(input int ret_edge, input int npulse);
        for (int k = 0; k < npulse; k++) exp_q.push_back(coord(k * 128, 0));
        @(negedge clk);
        rd_vs = 1'b1;
        for (int i = 0; i < 14; i++) begin
            credit_ret = (i == ret_edge);
            @(posedge clk);
            #1;
            chk($sformatf("valid_edge%0d", i), 32'(image_addr_valid), 32'((i >= 2) && (i < 2 + npulse)));
            if (i == 1) chk("busy_run", 32'(frame_busy), 32'd1);
            if (i == 3) rd_vs = 1'b0;
        end
        credit_ret = 1'b0;
        chk("busy_stall", 32'(frame_busy), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Single return while stalled: nothing after edge K, one pulse after K+1, then stall again.
    task automatic ret_step(input logic [31:0] exp);
        exp_q.push_back(exp);
        @(negedge clk);
        credit_ret = 1'b1;
        @(posedge clk);
        #1;
        credit_ret = 1'b0;
        chk("ret_edge_k", 32'(image_addr_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("ret_edge_k1", 32'(image_addr_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("ret_restall", 32'(image_addr_valid), 32'd0);
    endtask

    task automatic push_full_frame();
        for (int h = 0; h < 720; h++)
            for (int w = 0; w < 1280; w += 128)
                exp_q.push_back(coord(w, h));
    endtask

    task automatic wait_idle(input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!frame_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  snap;
        bit  found;

        // Reset values
        @(negedge clk);
        chk("rst_valid", 32'(image_addr_valid), 32'd0);
        chk("rst_addr", image_addr, 32'd0);
        chk("rst_busy", 32'(frame_busy), 32'd0);
`ifdef RD3_CG_ERR_EN
        chk("rst_err", 32'(err_flags), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // No returns: exactly CREDITS pulses along line 0, then stall; single returns continue and wrap.
        frame_pattern(-1, 8);
        ret_step(coord(1024, 0));
        ret_step(coord(1152, 0));
        ret_step(coord(0, 1));
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Issue and return together at credit 1: one extra back-to-back pulse.
        do_reset();
        frame_pattern(9, 9);

        // Return while full in IDLE is ignored: still only 8 pulses.
        do_reset();
        @(negedge clk);
        credit_ret = 1'b1;
        @(negedge clk);
        credit_ret = 1'b0;
        frame_pattern(-1, 8);
`ifdef RD3_CG_ERR_EN
        chk("err_credit_ovf", 32'(err_flags), 32'd1);
`endif

        // Full frame with returns tied high.
        do_reset();
        credit_ret = 1'b1;
        push_full_frame();
        pulse_cnt = 0;
        @(negedge clk);
        rd_vs = 1'b1;
        repeat (4) @(negedge clk);
        rd_vs = 1'b0;
        wait_idle(8000, "frame_done_bound");
        chk("frame_pulses", 32'(pulse_cnt), 32'd7200);
        chk("frame_b2b_span", 32'(last_cyc - first_cyc), 32'd7199);
        chk("frame_last_addr", last_addr, 32'h0480_02CF);
        chk("frame_done_busy", 32'(frame_busy), 32'd0);
        chk("frame_drained", 32'(exp_q.size()), 32'd0);
        repeat (10) @(negedge clk);

        // Restart at (0,100): (128,100) still issues, one gap cycle, then (0,0).
        for (int h = 0; h < 100; h++)
            for (int w = 0; w < 1280; w += 128)
                exp_q.push_back(coord(w, h));
        exp_q.push_back(coord(0, 100));
        exp_q.push_back(coord(128, 100));
        push_full_frame();
        @(negedge clk);
        rd_vs = 1'b1;
        repeat (4) @(negedge clk);
        rd_vs = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (image_addr_valid && image_addr == coord(0, 100)) begin
                found = 1'b1;
                break;
            end
        end
        chk("restart_reach_h100", 32'(found), 32'd1);
        rd_vs = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_edge_n", 32'(image_addr_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("restart_gap", 32'(image_addr_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("restart_first", image_addr, coord(0, 0));
        rd_vs = 1'b0;
        wait_idle(8000, "restart_done_bound");
        chk("restart_drained", 32'(exp_q.size()), 32'd0);
`ifdef RD3_CG_ERR_EN
        chk("err_frame_ovr", 32'(err_flags[1]), 32'd1);
`endif

        // Reset during a valid pulse clears outputs at once; no pulses until a new rise.
        do_reset();
        credit_ret = 1'b1;
        push_full_frame();
        @(negedge clk);
        rd_vs = 1'b1;
        repeat (4) @(negedge clk);
        rd_vs = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_valid", 32'(image_addr_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(image_addr_valid), 32'd0);
        chk("async_rst_addr", image_addr, 32'd0);
        chk("async_rst_busy", 32'(frame_busy), 32'd0);
        exp_q.delete();
        credit_ret = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        snap = pulse_cnt;
        repeat (30) @(negedge clk);
        chk("post_rst_quiet", 32'(pulse_cnt - snap), 32'd0);
        chk("post_rst_busy", 32'(frame_busy), 32'd0);
`ifdef RD3_CG_ERR_EN
        chk("post_rst_err", 32'(err_flags), 32'd0);
`endif
        frame_pattern(-1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// Empty helper so the bench module list stays self-contained.
module push_frame_dummy;
endmodule
